// File: rtl/pwm_meter.sv
// pwm_meter: measures period and high time of an asynchronous PWM input
// in sys_clk cycles and flags an edge-less input after a timeout.
module pwm_meter #(
  parameter int CNT_W       = 16,
  parameter int CNT_TIMEOUT = 1000
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             timeout,
  output logic             stuck_level
);

  typedef enum logic {
    IDLE,
    MEAS
  } state_t;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(CNT_TIMEOUT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic pwm_m;
  logic pwm_s;
  logic pwm_d;
  logic rise;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_per_q;
  logic [CNT_W-1:0] cnt_per_d;
  logic [CNT_W-1:0] cnt_high_q;
  logic [CNT_W-1:0] cnt_high_d;
  logic [CNT_W-1:0] period_d;
  logic [CNT_W-1:0] high_d;
  logic             valid_d;
  logic             timeout_d;
  logic             stuck_d;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pwm_m <= 1'b0;
      pwm_s <= 1'b0;
      pwm_d <= 1'b0;
    end else begin
      pwm_m <= pwm_in;
      pwm_s <= pwm_m;
      pwm_d <= pwm_s;
    end
  end

  assign rise = pwm_s & ~pwm_d;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      cnt_per_q   <= '0;
      cnt_high_q  <= '0;
      period      <= '0;
      high_time   <= '0;
      valid       <= 1'b0;
      timeout     <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_per_q   <= cnt_per_d;
      cnt_high_q  <= cnt_high_d;
      period      <= period_d;
      high_time   <= high_d;
      valid       <= valid_d;
      timeout     <= timeout_d;
      stuck_level <= stuck_d;
    end
  end

  // The rise cycle is the first cycle of the new period, hence reload to 1.
  always_comb begin
    state_d    = state_q;
    cnt_per_d  = cnt_per_q;
    cnt_high_d = cnt_high_q;
    period_d   = period;
    high_d     = high_time;
    valid_d    = 1'b0;
    timeout_d  = timeout;
    stuck_d    = stuck_level;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          cnt_per_d  = ONE;
          cnt_high_d = ONE;
          timeout_d  = 1'b0;
          state_d    = MEAS;
        end
      end
      MEAS: begin
        if (rise) begin
          period_d   = cnt_per_q;
          high_d     = cnt_high_q;
          valid_d    = 1'b1;
          cnt_per_d  = ONE;
          cnt_high_d = ONE;
        end else if (cnt_per_q == TMO) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
          stuck_d   = pwm_s;
        end else begin
          cnt_per_d = cnt_per_q + ONE;
          if (pwm_s) begin
            cnt_high_d = cnt_high_q + ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
